l2_line_burst_adaptor: RTL

- Memory-side responder for the L2 line interface.
- Accepts one 256-bit line read or write from the L2 cache at a time.
- Performs it as a 4-beat, 64-bit burst on the physical-memory port.
- Returns line_resp_o to the L2 when the burst completes, and line_rdata_o for reads.

---
 rtl/l2_adaptor_pkg.sv | 11 +
 rtl/l2_line_buf.sv | 29 ++
 rtl/l2_line_burst_adaptor.sv | 82 ++++++++
 3 files changed

// File: rtl/l2_adaptor_pkg.sv
// l2_adaptor_pkg: shared sizes and FSM state type for the L2 line burst adaptor
package l2_adaptor_pkg;
  localparam int ADDR_W   = 32;
  localparam int S_OFFSET = 5;
  localparam int LINE_W   = 8 * (2 ** S_OFFSET);
  localparam int BEAT_W   = 64;
  localparam int N_BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W    = 2;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << S_OFFSET) - 1);
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;
endpackage

// File: rtl/l2_line_buf.sv
// l2_line_buf: line register with whole-line load, per-beat load and indexed beat read
module l2_line_buf
  import l2_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_line_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              load_beat_i,
  input  logic [CNT_W-1:0]  idx_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic [LINE_W-1:0] line_o,
  output logic [BEAT_W-1:0] beat_o
);
  logic [LINE_W-1:0] line_q, line_d;
  // whole-line load takes priority over a single beat
  always_comb begin
    line_d = line_q;
    if (load_line_i) line_d = line_i;
    else if (load_beat_i) line_d[BEAT_W*idx_i +: BEAT_W] = beat_i;
  end
  // line storage, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) line_q <= '0;
    else line_q <= line_d;
  end
  assign line_o = line_q;
  assign beat_o = line_q[BEAT_W*idx_i +: BEAT_W];
endmodule

// File: rtl/l2_line_burst_adaptor.sv
// l2_line_burst_adaptor: serves one L2 line read/write as a 4-beat 64-bit pmem burst
module l2_line_burst_adaptor
  import l2_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [ADDR_W-1:0] line_addr_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  output logic [LINE_W-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic              pmem_read_o,
  output logic              pmem_write_o,
  output logic [ADDR_W-1:0] pmem_addr_o,
  output logic [BEAT_W-1:0] pmem_wdata_o,
  input  logic [BEAT_W-1:0] pmem_rdata_i,
  input  logic              pmem_resp_i
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] rdata_q, rdata_d, buf_line;
  logic              beat_acc, last_beat, cap_wr, cap_any;
  assign cap_wr    = state_q == IDLE && line_write_i;
  assign cap_any   = state_q == IDLE && (line_write_i || line_read_i);
  assign beat_acc  = pmem_resp_i && (state_q == RD_BURST || state_q == WR_BURST);
  assign last_beat = beat_acc && cnt_q == CNT_W'(N_BEATS - 1);
  // state, beat counter, captured address and completed read line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end
  // next state: write beats read on a tie; the held read is picked up after DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = line_write_i ? WR_BURST : line_read_i ? RD_BURST : IDLE;
      RD_BURST: state_d = last_beat ? DONE : RD_BURST;
      WR_BURST: state_d = last_beat ? DONE : WR_BURST;
      default:  state_d = IDLE;
    endcase
  end
  // datapath next values: aligned address capture, beat count, read line publish
  always_comb begin
    addr_d  = cap_any ? (line_addr_i & ~OFF_MASK) : addr_q;
    cnt_d   = beat_acc ? cnt_q + 1'b1 : cnt_q;
    rdata_d = rdata_q;
    if (last_beat && state_q == RD_BURST) begin
      rdata_d = buf_line;
      rdata_d[LINE_W-1 -: BEAT_W] = pmem_rdata_i;
    end
  end
  // outputs decoded from state
  always_comb begin
    pmem_read_o  = state_q == RD_BURST;
    pmem_write_o = state_q == WR_BURST;
    line_resp_o  = state_q == DONE;
  end
  assign pmem_addr_o  = addr_q;
  assign line_rdata_o = rdata_q;
  l2_line_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .load_line_i (cap_wr),
    .line_i      (line_wdata_i),
    .load_beat_i (beat_acc && state_q == RD_BURST),
    .idx_i       (cnt_q),
    .beat_i      (pmem_rdata_i),
    .line_o      (buf_line),
    .beat_o      (pmem_wdata_o)
  );
endmodule
